// File: rtl/miss_queue.sv
`default_nettype none
// ============================================================================
// miss_queue : merging line-fill request queue, I-cache miss path -> next level
// Revision 1.0
// ============================================================================
module miss_queue #(
  parameter int DEPTH    = 4,
  parameter int AW       = 26,
  parameter int LINE_LSB = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [AW-1:0]          in_addr,
  output logic                   in_ready,
  output logic                   mem_valid,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ready,
  output logic [31:0]            issued,
  output logic [31:0]            merged,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = AW - LINE_LSB;
  localparam logic [CW-1:0] c_count_full = CW'(DEPTH);

  // Only the line tag is stored; the byte offset is always zero on the way out.
  logic [TW-1:0]    r_tag [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_issued;
  logic [31:0]      r_merged;

  logic [TW-1:0]    w_in_tag;
  logic [DEPTH-1:0] w_hit;
  logic             w_accept;
  logic             w_merge;
  logic             w_write;
  logic             w_issue;
  logic             w_unused_offset;

  assign w_in_tag        = in_addr[AW-1:LINE_LSB];
  assign w_unused_offset = ^in_addr[LINE_LSB-1:0];

  // The head still holds its valid bit while leaving, so it matches as well.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_hit[i] = r_vld[i] && (r_tag[i] == w_in_tag);
  end

  assign in_ready  = (r_count != c_count_full);
  assign mem_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_merge   = w_accept && (|w_hit);
  assign w_write   = w_accept && !(|w_hit);
  assign w_issue   = mem_valid && mem_ready;

  assign mem_addr  = mem_valid ? (AW'(r_tag[r_head]) << LINE_LSB) : '0;
  assign issued    = r_issued;
  assign merged    = r_merged;
  assign occupancy = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
      r_vld    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_issued <= '0;
      r_merged <= '0;
    end else if (flush) begin
      r_vld    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_issued <= '0;
      r_merged <= '0;
    end else begin
      // Head and tail never alias here: issue needs count>0, write needs count<DEPTH.
      if (w_issue) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
        r_issued      <= r_issued + 32'd1;
      end
      if (w_write) begin
        r_vld[r_tail] <= 1'b1;
        r_tag[r_tail] <= w_in_tag;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_merge) begin
        r_merged <= r_merged + 32'd1;
      end
      r_count <= r_count + CW'(w_write) - CW'(w_issue);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miss_queue.sv
`default_nettype none
// ============================================================================
// tb_miss_queue : directed scoreboard bench for miss_queue
// Revision 1.0
// ============================================================================
module tb_miss_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [25:0] in_addr;
  logic        in_ready;
  logic        mem_valid;
  logic [25:0] mem_addr;
  logic        mem_ready;
  logic [31:0] issued;
  logic [31:0] merged;
  logic [2:0]  occupancy;

  int          n_vec;
  int          n_err;
  int          max_occ;
  logic [25:0] sb[$];

  miss_queue #(.DEPTH(4), .AW(26), .LINE_LSB(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_ready  (in_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .issued    (issued),
    .merged    (merged),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard on every mem handshake and checks stall stability.
  initial begin
    bit          stalled;
    logic [25:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        if (stalled && mem_valid) check("stall_hold", 32'(mem_addr), 32'(held));
        stalled = mem_valid && !mem_ready && !flush;
        held    = mem_addr;
        if (mem_valid && mem_ready && !flush) begin
          if (sb.size() == 0) begin
            check("unexpected_issue", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            check("issue_addr", 32'(mem_addr), 32'(sb.pop_front()));
          end
        end
      end
    end
  end

  // Entry and exit at posedge+1; expected line address queued unless a merge is expected.
  task automatic push(input logic [25:0] a, input bit merge);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_addr  = a;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    else if (!merge) sb.push_back(a & ~26'h3F);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((mem_valid || occupancy != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (mem_valid || occupancy != 0) check("drain_timeout", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    max_occ   = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    mem_ready = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_issued",    issued,         32'd0);
    check("rst_merged",    merged,         32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, one-cycle latency, immediate handshake.
    mem_ready = 1'b1;
    push(26'h0000040, 1'b0);
    check("lat_mem_valid", 32'(mem_valid), 32'd1);
    check("lat_mem_addr",  32'(mem_addr),  32'h40);
    check("lat_occupancy", 32'(occupancy), 32'd1);
    @(posedge clk);
    #1;
    check("hs_issued",    issued,         32'd1);
    check("hs_occupancy", 32'(occupancy), 32'd0);
    check("hs_mem_valid", 32'(mem_valid), 32'd0);

    // Same-line merge under stall.
    mem_ready = 1'b0;
    push(26'h040, 1'b0);
    push(26'h07F, 1'b1);
    push(26'h080, 1'b0);
    check("merge_count",     merged,         32'd1);
    check("merge_occupancy", 32'(occupancy), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    wait_drain();
    mem_ready = 1'b0;
    check("merge_issued", issued, 32'd3);

    // Fill to DEPTH, hold the fifth line, release with a single mem_ready pulse.
    push(26'h000, 1'b0);
    push(26'h040, 1'b0);
    push(26'h080, 1'b0);
    push(26'h0C0, 1'b0);
    check("full_in_ready",  32'(in_ready),  32'd0);
    check("full_occupancy", 32'(occupancy), 32'd4);
    in_valid = 1'b1;
    in_addr  = 26'h100;
    sb.push_back(26'h100);
    repeat (2) @(posedge clk);
    #1;
    check("full_held", 32'(occupancy), 32'd4);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("full_ready_back", 32'(in_ready),  32'd1);
    check("full_after_pop",  32'(occupancy), 32'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_refill", 32'(occupancy), 32'd4);
    mem_ready = 1'b1;
    wait_drain();

    // Clear counters, then stream 10 lines back to back.
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_issued", issued, 32'd0);
    check("flush_merged", merged, 32'd0);
    max_occ  = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_addr = 26'(32'h1000 + i * 64);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      sb.push_back(in_addr);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("stream_issued",  issued,        32'd10);
    check("stream_max_occ", 32'(max_occ),  32'd1);

    // Flush wins over a same-cycle accept.
    mem_ready = 1'b0;
    push(26'h300, 1'b0);
    push(26'h310, 1'b1);
    push(26'h340, 1'b0);
    push(26'h380, 1'b0);
    check("pre_flush_occ",    32'(occupancy), 32'd3);
    check("pre_flush_merged", merged,         32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 26'h200;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("post_flush_occ",       32'(occupancy), 32'd0);
    check("post_flush_mem_valid", 32'(mem_valid), 32'd0);
    check("post_flush_issued",    issued,         32'd0);
    check("post_flush_merged",    merged,         32'd0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("flush_drop_0x200", 32'(mem_valid), 32'd0);

    // Asynchronous reset mid-cycle while a request is offered.
    push(26'h480, 1'b0);
    wait_drain();
    check("pre_rst_issued", issued, 32'd1);
    mem_ready = 1'b0;
    push(26'h500, 1'b0);
    check("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_mem_valid", 32'(mem_valid), 32'd0);
    check("arst_mem_addr",  32'(mem_addr),  32'd0);
    check("arst_issued",    issued,         32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("post_rst_occupancy", 32'(occupancy), 32'd0);
    push(26'h540, 1'b0);
    wait_drain();
    check("post_rst_issued", issued, 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
